slot_allocator: RTL and testbench

Registered, parametrised slot allocator for the component manager. It keeps a busy bitmap of DEPTH hardware slots and grants the lowest-index free slot on request. Slots are freed by index.
It replaces ad-hoc use of a combinational first-set-bit search with a clocked request/grant interface. It also adds occupancy tracking and error reporting.

---
 rtl/slot_alloc_pkg.sv | 22 ++
 rtl/slot_allocator_if.sv | 28 ++
 rtl/lowest_free_encoder.sv | 27 ++
 rtl/slot_allocator.sv | 100 ++++++++++
 tb/tb_slot_allocator.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/slot_alloc_pkg.sv
// rtl/slot_alloc_pkg.sv - shared constants, status pulse type and popcount helper for the slot allocator
package slot_alloc_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;

  typedef struct packed {
    logic gnt;
    logic fail;
    logic err;
  } status_t;

  // Used at elaboration to derive the reset occupancy from RESET_BUSY_MAP.
  function automatic int popcount(input logic [255:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/slot_allocator_if.sv
// rtl/slot_allocator_if.sv - request/grant/free bus and status outputs of the slot allocator
interface slot_allocator_if #(
  parameter int ADDR_WIDTH = 3
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  alloc_req;
  logic                  free_req;
  logic [ADDR_WIDTH-1:0] free_addr;
  logic                  alloc_gnt;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  alloc_fail;
  logic                  free_err;
  logic [DEPTH-1:0]      busy_map;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;

  modport master (
    output alloc_req, free_req, free_addr,
    input  alloc_gnt, alloc_addr, alloc_fail, free_err, busy_map, count, full, empty
  );

  modport slave (
    input  alloc_req, free_req, free_addr,
    output alloc_gnt, alloc_addr, alloc_fail, free_err, busy_map, count, full, empty
  );
endinterface

// File: rtl/lowest_free_encoder.sv
// rtl/lowest_free_encoder.sv - combinational search for the first free slot at or after a start offset
module lowest_free_encoder #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic [(1<<ADDR_WIDTH)-1:0] busy,
  input  logic [ADDR_WIDTH-1:0]      start,
  output logic                       hit,
  output logic [ADDR_WIDTH-1:0]      index
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Scan from the farthest offset down so the nearest free slot wins; the index add wraps mod DEPTH.
  always_comb begin
    logic [ADDR_WIDTH-1:0] cand;
    hit   = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      cand = start + ADDR_WIDTH'(i);
      if (!busy[cand]) begin
        hit   = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// rtl/slot_allocator.sv - registered slot allocator; SLOT_ALLOC_ROUND_ROBIN_EN selects rotating search
module slot_allocator
  import slot_alloc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int DEPTH = 1 << ADDR_WIDTH,
  parameter logic [DEPTH-1:0] RESET_BUSY_MAP = '0
) (
  input logic            clk,
  input logic            rst_n,
  slot_allocator_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] RESET_COUNT = (ADDR_WIDTH+1)'(popcount(256'(RESET_BUSY_MAP)));
  localparam logic [ADDR_WIDTH:0] FULL_COUNT  = (ADDR_WIDTH+1)'(DEPTH);

  logic [DEPTH-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  status_t               status_q, status_d;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0] start;
  logic                  alloc_ok;
  logic                  free_ok;

`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
  logic [ADDR_WIDTH-1:0] last_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= '0;
    end else if (alloc_ok) begin
      last_ptr <= index;
    end
  end

  assign start = last_ptr + ADDR_WIDTH'(1);
`else
  assign start = '0;
`endif

  lowest_free_encoder #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_encoder (
    .busy (busy_q),
    .start(start),
    .hit  (hit),
    .index(index)
  );

  assign alloc_ok = bus.alloc_req && hit;
  assign free_ok  = bus.free_req && busy_q[bus.free_addr];

  // Search runs on the pre-free map, so a slot freed this cycle can never collide with the grant.
  always_comb begin
    busy_d   = busy_q;
    count_d  = count_q;
    addr_d   = addr_q;
    status_d = '{gnt: alloc_ok,
                 fail: bus.alloc_req && !hit,
                 err: bus.free_req && !busy_q[bus.free_addr]};
    if (alloc_ok) begin
      busy_d[index] = 1'b1;
      addr_d        = index;
    end
    if (free_ok) begin
      busy_d[bus.free_addr] = 1'b0;
    end
    case ({alloc_ok, free_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= RESET_BUSY_MAP;
      count_q  <= RESET_COUNT;
      addr_q   <= '0;
      status_q <= '0;
    end else begin
      busy_q   <= busy_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      status_q <= status_d;
    end
  end

  assign bus.alloc_gnt  = status_q.gnt;
  assign bus.alloc_fail = status_q.fail;
  assign bus.free_err   = status_q.err;
  assign bus.alloc_addr = addr_q;
  assign bus.busy_map   = busy_q;
  assign bus.count      = count_q;
  assign bus.full       = (count_q == FULL_COUNT);
  assign bus.empty      = (count_q == '0);

endmodule

// File: tb/tb_slot_allocator.sv
// tb/tb_slot_allocator.sv - scoreboard bench for slot_allocator with directed and random traffic
module tb_slot_allocator;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    bit       gnt;
    bit       fail;
    bit       err;
    bit [2:0] addr;
    bit [7:0] map;
    int       cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  bit       mbusy[DEPTH];
  bit [2:0] maddr;
  bit [2:0] mptr;

  slot_allocator_if #(.ADDR_WIDTH(AW)) bus ();

  slot_allocator #(
    .ADDR_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t snapshot(input bit g, input bit f, input bit e);
    exp_t r;
    r.gnt  = g;
    r.fail = f;
    r.err  = e;
    r.addr = maddr;
    r.map  = '0;
    r.cnt  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      r.map[i] = mbusy[i];
      r.cnt   += int'(mbusy[i]);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mbusy[i] = 1'b0;
    maddr = '0;
    mptr  = '0;
  endtask

  // Reference: walk slots from the start point, take the first free one; frees judged on the old map.
  task automatic model_step(input bit a, input bit f, input bit [2:0] fa);
    int  start;
    int  slot;
    bit  found;
    bit  g, fl, e, free_ok;
`ifdef SLOT_ALLOC_ROUND_ROBIN_EN
    start = (int'(mptr) + 1) % DEPTH;
`else
    start = 0;
`endif
    found = 1'b0;
    slot  = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && !mbusy[(start + k) % DEPTH]) begin
        found = 1'b1;
        slot  = (start + k) % DEPTH;
      end
    end
    g       = a && found;
    fl      = a && !found;
    free_ok = f && mbusy[fa];
    e       = f && !mbusy[fa];
    if (g) begin
      mbusy[slot] = 1'b1;
      maddr       = 3'(slot);
      mptr        = 3'(slot);
    end
    if (free_ok) mbusy[fa] = 1'b0;
    q.push_back(snapshot(g, fl, e));
  endtask

  task automatic cycle(input bit a, input bit f, input bit [2:0] fa);
    @(negedge clk);
    bus.alloc_req = a;
    bus.free_req  = f;
    bus.free_addr = fa;
    model_step(a, f, fa);
  endtask

  // Reset lands between edges with an alloc pending, so that request must vanish.
  task automatic do_reset();
    @(negedge clk);
    bus.alloc_req = 1'b1;
    bus.free_req  = 1'b0;
    bus.free_addr = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(bus.alloc_gnt), 0);
    chk("rst_fail", 32'(bus.alloc_fail), 0);
    chk("rst_err", 32'(bus.free_err), 0);
    chk("rst_addr", 32'(bus.alloc_addr), 0);
    chk("rst_map", 32'(bus.busy_map), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    model_reset();
    q.push_back(snapshot(1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.alloc_req = 1'b0;
    model_step(1'b0, 1'b0, 3'd0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt", 32'(bus.alloc_gnt), 32'(e.gnt));
      chk("fail", 32'(bus.alloc_fail), 32'(e.fail));
      chk("err", 32'(bus.free_err), 32'(e.err));
      chk("addr", 32'(bus.alloc_addr), 32'(e.addr));
      chk("map", 32'(bus.busy_map), 32'(e.map));
      chk("count", 32'(bus.count), 32'(e.cnt));
      chk("full", 32'(bus.full), 32'(e.cnt == DEPTH));
      chk("empty", 32'(bus.empty), 32'(e.cnt == 0));
      chk("count_range", 32'(bus.count <= 4'(DEPTH)), 1);
    end
  end

  initial begin
    bus.alloc_req = 1'b0;
    bus.free_req  = 1'b0;
    bus.free_addr = '0;
    model_reset();

    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 3'd3);
    cycle(1'b1, 1'b0, 3'd0);

    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd1);

    do_reset();
    cycle(1'b0, 1'b1, 3'd5);

    do_reset();
    cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b0, 1'b1, 3'd0);
    cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b1, 1'b0, 3'd0);
    do_reset();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 3'($urandom_range(0, DEPTH - 1)));
      end
    end
    cycle(1'b0, 1'b0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
